// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared state encoding and defaults for the memory stage
package mem_stage_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int MAX_WAIT_DEF = 15;
  localparam int CNT_W_DEF    = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HALT = 3'd3,
    ERR  = 3'd4
  } stateT;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// rtl/mem_stage_ctrl_if.sv - request/done bus between the memory stage and data memory
interface mem_stage_ctrl_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] memAddr;
  logic [DATA_W-1:0] memDataIn;
  logic              memRd;
  logic              memWr;
  logic              memStall;
  logic              memDone;
  logic [DATA_W-1:0] memDataOut;

  modport master (
    output memAddr, memDataIn, memRd, memWr,
    input  memStall, memDone, memDataOut
  );

  modport slave (
    input  memAddr, memDataIn, memRd, memWr,
    output memStall, memDone, memDataOut
  );
endinterface

// File: rtl/mem_stage_ctrl_wait_cnt.sv
// rtl/mem_stage_ctrl_wait_cnt.sv - watchdog counter for outstanding memory accesses
module mem_wait_cnt #(
  parameter int CNT_W    = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // High during the MAX_WAIT-th counted cycle, so the stage leaves on the next edge
  assign expired = inc && (cnt == LAST);

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory stage FSM and datapath; UNALIGNED_ERR_EN makes odd addresses an error
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exValid,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              halt,
  input  logic [DATA_W-1:0] aluOut,
  input  logic [DATA_W-1:0] wrtData,
  mem_stage_ctrl_if.master  memBus,
  output logic [DATA_W-1:0] wbData,
  output logic              wbValid,
  output logic              stallPipe,
  output logic              err,
  output logic              halted
);

  stateT             state;
  stateT             nextState;
  logic              opLoad;
  logic [DATA_W-1:0] latAddr;
  logic [DATA_W-1:0] latData;
  logic              memOp;
  logic              bothOp;
  logic              badAlign;
  logic              accept;
  logic              cntInc;
  logic              expired;

  function automatic logic [DATA_W-1:0] alignAddr(input logic [DATA_W-1:0] a);
`ifdef UNALIGNED_ERR_EN
    return a;
`else
    return {a[DATA_W-1:1], 1'b0};
`endif
  endfunction

  assign memOp  = memRead | memWrite;
  assign bothOp = memRead & memWrite;
`ifdef UNALIGNED_ERR_EN
  assign badAlign = aluOut[0];
`else
  assign badAlign = 1'b0;
`endif

  assign accept = (state == IDLE) && exValid && !halt && memOp && !bothOp && !badAlign;
  assign cntInc = (state == REQ) || (state == WAIT);

  mem_wait_cnt #(
    .CNT_W    (CNT_W),
    .MAX_WAIT (MAX_WAIT)
  ) uWaitCnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .inc     (cntInc),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Operands are captured at acceptance and held until retire for REQ re-drives and store write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      opLoad  <= 1'b0;
      latAddr <= '0;
      latData <= '0;
    end else if (accept) begin
      opLoad  <= memRead;
      latAddr <= aluOut;
      latData <= wrtData;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (exValid) begin
          if (halt) begin
            nextState = HALT;
          end else if (bothOp || (memOp && badAlign)) begin
            nextState = ERR;
          end else if (memOp) begin
            nextState = memBus.memStall ? REQ : WAIT;
          end
        end
      end
      REQ: begin
        if (expired) begin
          nextState = ERR;
        end else if (!memBus.memStall) begin
          nextState = WAIT;
        end
      end
      WAIT: begin
        if (memBus.memDone) begin
          nextState = IDLE;
        end else if (expired) begin
          nextState = ERR;
        end
      end
      HALT:    nextState = HALT;
      ERR:     nextState = ERR;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    memBus.memAddr   = '0;
    memBus.memDataIn = '0;
    memBus.memRd     = 1'b0;
    memBus.memWr     = 1'b0;
    wbData           = '0;
    wbValid          = 1'b0;
    stallPipe        = 1'b0;
    err              = 1'b0;
    halted           = 1'b0;
    case (state)
      IDLE: begin
        if (exValid) begin
          if (halt || bothOp || (memOp && badAlign)) begin
            stallPipe = 1'b1;
          end else if (memOp) begin
            memBus.memRd     = memRead;
            memBus.memWr     = memWrite;
            memBus.memAddr   = alignAddr(aluOut);
            memBus.memDataIn = wrtData;
            stallPipe        = 1'b1;
          end else begin
            wbValid = 1'b1;
            wbData  = aluOut;
          end
        end
      end
      REQ: begin
        memBus.memRd     = opLoad;
        memBus.memWr     = !opLoad;
        memBus.memAddr   = alignAddr(latAddr);
        memBus.memDataIn = latData;
        stallPipe        = 1'b1;
      end
      WAIT: begin
        stallPipe = 1'b1;
        if (memBus.memDone) begin
          wbValid   = 1'b1;
          stallPipe = 1'b0;
          wbData    = opLoad ? memBus.memDataOut : latAddr;
        end
      end
      HALT: begin
        halted    = 1'b1;
        stallPipe = 1'b1;
      end
      ERR: begin
        err       = 1'b1;
        stallPipe = 1'b1;
      end
      default: begin
        stallPipe = 1'b0;
      end
    endcase
  end

endmodule
